calc_cmd_sequencer: RTL
=======================

# calc_cmd_sequencer

Front-end command sequencer sitting directly upstream of the queue calculator. It parses a byte stream of framed commands, drives the calculator's operand/opcode/apply inputs, and waits a fixed settle time. It then samples the calculator's tail/empty/error outputs and returns one status response per command over a ready/valid output channel. Malformed headers are dropped and counted.

## Interface

Parameters:
- SYNC, 5'b10100: required value of header bits [7:3].
- PUSH_OP, 3'd0: opcode that carries an operand byte; every other opcode is operand-less.
- SETTLE, 2: cycles from the apply pulse to the status sample; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_data  in  8  command stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  sequencer accepts a byte this cycle.
- calc_in  out  8  operand to the calculator (`in`).
- calc_op  out  3  opcode to the calculator (`op`).
- calc_apply  out  1  single-cycle apply strobe.
- calc_tail  in  8  calculator tail value.
- calc_empty  in  1  calculator queue empty.
- calc_err  in  1  calculator error flag (its `valid` output).
- m_data  out  8  sampled tail.
- m_flags  out  2  {err, empty}, as sampled.
- m_valid  out  1  response valid.
- m_ready  in  1  response consumer ready.
- bad_cnt  out  8  rejected-header count; saturates at 255.
- busy  out  1  high in every state except HDR.

## Operation

- The FSM has five states: HDR, OPND, ISSUE, SETTLE, RESP. After reset it is in HDR.
- s_ready is 1 only in HDR and OPND. A byte is consumed on s_valid & s_ready.
- HDR, header consumed:
  - If bits [7:3] != SYNC: drop the byte, increment bad_cnt (saturating), stay in HDR.
  - Otherwise latch calc_op = bits [2:0]. If the opcode equals PUSH_OP, go to OPND. Otherwise latch calc_in = 0 and go to ISSUE.
- OPND: a consumed byte is latched into calc_in, then go to ISSUE. The byte is never checked for SYNC. OPND waits indefinitely for s_valid.
- ISSUE: calc_apply = 1 for exactly this cycle. Load the settle counter with SETTLE, then go to SETTLE.
- SETTLE: decrement the counter each cycle. In the cycle the counter reaches 0, register m_data = calc_tail and m_flags = {calc_err, calc_empty}, then go to RESP.
- RESP: m_valid = 1, with m_data and m_flags held stable. On m_ready, go to HDR.
- m_ready while m_valid = 0 is ignored.
- calc_in and calc_op hold their latched values until the next header or operand is latched. They do not return to 0 after apply.
- One command is in flight at a time. There is no input buffering; backpressure comes solely from s_ready.

## Timing

- Reset values: s_ready 0, then 1 from the first cycle after rst deasserts. calc_in 0, calc_op 0, calc_apply 0, m_data 0, m_flags 0, m_valid 0, bad_cnt 0, busy 0.
- Non-push command, header consumed at edge T:
  - calc_apply is high in cycle T+1.
  - The sample edge is T+1+SETTLE.
  - m_valid is high from cycle T+2+SETTLE.
- Push command: the same latencies apply, measured from the edge that consumes the operand byte.
- With m_ready held at 1, a non-push command occupies 3+SETTLE cycles from header acceptance to HDR. The next header can be accepted in the first HDR cycle.
- m_valid with m_ready in the same cycle completes the response. m_valid drops the next cycle and s_ready rises the same cycle.
- Reset asserted mid-command (any state) returns every output to its reset value immediately. A partial frame (header without operand) is discarded. Any pending response is lost.
- bad_cnt at 255 stays at 255 on further bad headers. It clears only on reset.
- calc_err is sampled, not interpreted: an error response is still a normal response.

## Structure

- Package calc_seq_pkg holds the FSM state enum (HDR, OPND, ISSUE, SETTLE, RESP), the default SYNC and PUSH_OP constants, and the m_flags bit indices (FLAG_ERR = 1, FLAG_EMPTY = 0).
- One sub-module is natural: sat_cnt8, an 8-bit saturating increment counter with asynchronous active-low reset, used for bad_cnt.
- The FSM, operand latch, settle counter and response register live in calc_cmd_sequencer.

## Test plan

- Reset release, then header 8'hA3 (SYNC, op 3) with m_ready = 1:
  - calc_op = 3 and calc_in = 0.
  - calc_apply is high exactly one cycle after acceptance.
  - m_valid rises SETTLE+1 cycles after apply, with m_data equal to calc_tail as driven at the sample edge.
- Header 8'hA0, then operand 8'h5C: calc_in = 8'h5C and calc_op = 0. The apply occurs one cycle after the operand is accepted. s_ready is low from ISSUE through RESP.
- Header 8'h13 (bad sync): no calc_apply, bad_cnt goes 0 to 1, and s_ready stays high. Send 300 bad headers: bad_cnt = 255.
- m_ready held low for 10 cycles in RESP: m_valid, m_data and m_flags stay stable, and s_ready stays low. m_ready = 1 completes the response and the FSM returns to HDR the next cycle.
- Drive calc_err = 1 and calc_empty = 1 at the sample edge: m_flags = 2'b11.
- rst asserted while in OPND after header 8'hA0: all outputs go to reset values. After release, 8'hA2 is treated as a fresh header (op 2), not as an operand.

Source files
------------

// File: rtl/calc_seq_pkg.sv
// Shared types and constants for the calculator command sequencer.
package calc_seq_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_OPND,
        ST_ISSUE,
        ST_SETTLE,
        ST_RESP
    } state_e;

    localparam logic [4:0] SYNC_DEFAULT    = 5'b10100;
    localparam logic [2:0] PUSH_OP_DEFAULT = 3'd0;

    // Bit positions inside m_flags.
    localparam int unsigned FLAG_ERR   = 1;
    localparam int unsigned FLAG_EMPTY = 0;

endpackage

// File: rtl/calc_cmd_sequencer_sat_cnt8.sv
// 8-bit up counter that sticks at 255; cleared only by reset.
module sat_cnt8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] cnt
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Parses framed command bytes, drives the queue calculator, waits a fixed
// settle time and returns one sampled status response per command.
module calc_cmd_sequencer
    import calc_seq_pkg::*;
#(
    parameter logic [4:0]  SYNC    = SYNC_DEFAULT,
    parameter logic [2:0]  PUSH_OP = PUSH_OP_DEFAULT,
    parameter int unsigned SETTLE  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] calc_in,
    output logic [2:0] calc_op,
    output logic       calc_apply,
    input  logic [7:0] calc_tail,
    input  logic       calc_empty,
    input  logic       calc_err,
    output logic [7:0] m_data,
    output logic [1:0] m_flags,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] bad_cnt,
    output logic       busy
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_e     state_q,  state_d;
    logic [7:0] cin_q,    cin_d;
    logic [2:0] cop_q,    cop_d;
    logic [3:0] cnt_q,    cnt_d;
    logic [7:0] mdata_q,  mdata_d;
    logic [1:0] mflags_q, mflags_d;
    logic       bad_inc;
    logic       s_fire;

    // Gating with rst keeps s_ready low while reset is held, even though
    // the state register already reads HDR.
    assign s_ready = rst && ((state_q == ST_HDR) || (state_q == ST_OPND));
    assign s_fire  = s_valid && s_ready;

    always_comb begin
        state_d  = state_q;
        cin_d    = cin_q;
        cop_d    = cop_q;
        cnt_d    = cnt_q;
        mdata_d  = mdata_q;
        mflags_d = mflags_q;
        bad_inc  = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (s_fire) begin
                    if (s_data[7:3] != SYNC) begin
                        bad_inc = 1'b1;
                    end else begin
                        cop_d = s_data[2:0];
                        if (s_data[2:0] == PUSH_OP) begin
                            state_d = ST_OPND;
                        end else begin
                            cin_d   = 8'd0;
                            state_d = ST_ISSUE;
                        end
                    end
                end
            end
            ST_OPND: begin
                if (s_fire) begin
                    cin_d   = s_data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = SETTLE_LD;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // The edge that takes the counter from 1 to 0 is the sample edge.
                if (cnt_q <= 4'd1) begin
                    cnt_d                = 4'd0;
                    mdata_d              = calc_tail;
                    mflags_d[FLAG_ERR]   = calc_err;
                    mflags_d[FLAG_EMPTY] = calc_empty;
                    state_d              = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (m_ready) begin
                    state_d = ST_HDR;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_HDR;
            cin_q    <= 8'd0;
            cop_q    <= 3'd0;
            cnt_q    <= 4'd0;
            mdata_q  <= 8'd0;
            mflags_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            cin_q    <= cin_d;
            cop_q    <= cop_d;
            cnt_q    <= cnt_d;
            mdata_q  <= mdata_d;
            mflags_q <= mflags_d;
        end
    end

    sat_cnt8 u_bad_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bad_inc),
        .cnt (bad_cnt)
    );

    assign calc_in    = cin_q;
    assign calc_op    = cop_q;
    assign calc_apply = (state_q == ST_ISSUE);
    assign m_data     = mdata_q;
    assign m_flags    = mflags_q;
    assign m_valid    = (state_q == ST_RESP);
    assign busy       = (state_q != ST_HDR);

endmodule
